// File: rtl/multi_port_wakeup_queue.sv
// Unordered multi-port issue queue. Each entry holds one source tag and a payload.
// A tag-wakeup broadcast marks waiting entries ready. Up to SelWidth ready entries
// issue per cycle, lowest index first. Free slots are handed to enqueue ports in
// ascending index order, one slot per port position.
module multi_port_wakeup_queue #(
   parameter int Depth     = 8,
   parameter int EnqWidth  = 2,
   parameter int SelWidth  = 2,
   parameter int DataWidth = 8,
   parameter int TagWidth  = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush_i,
   input  logic [EnqWidth-1:0]                 enq_vld_i,
   output logic [EnqWidth-1:0]                 enq_rdy_o,
   input  logic [EnqWidth*DataWidth-1:0]       enq_data_i,
   input  logic [EnqWidth*TagWidth-1:0]        enq_tag_i,
   input  logic [EnqWidth-1:0]                 enq_srdy_i,
   input  logic                                wkup_vld_i,
   input  logic [TagWidth-1:0]                 wkup_tag_i,
   output logic [SelWidth-1:0]                 deq_vld_o,
   input  logic [SelWidth-1:0]                 deq_rdy_i,
   output logic [SelWidth*DataWidth-1:0]       deq_data_o,
   output logic [SelWidth*$clog2(Depth)-1:0]   deq_idx_o,
   output logic [$clog2(Depth+1)-1:0]          count_o
);

   localparam int IdxWidth = $clog2(Depth);
   localparam int CntWidth = $clog2(Depth+1);

   logic [Depth-1:0]                 vld_q, rdy_q;
   logic [Depth-1:0]                 vld_nxt, rdy_nxt;
   logic [TagWidth-1:0]              tag_q  [Depth];
   logic [DataWidth-1:0]             data_q [Depth];

   logic [EnqWidth-1:0][Depth-1:0]   enq_mask;
   logic [SelWidth-1:0][Depth-1:0]   result_mask;
   logic [Depth-1:0]                 enq_taken, sel_taken;
   logic [Depth-1:0]                 sel_mask;
   logic [Depth-1:0]                 deq_clr;
   logic [EnqWidth-1:0]              enq_fire, enq_we;
   logic [SelWidth-1:0]              deq_fire;

   logic                             err_deq_invalid, err_enq_overlap, err_sel_overlap;

   // Static priority selection: k-th lowest free slot per enqueue port, k-th lowest ready entry per issue port.
   always_comb begin
      enq_mask    = '0;
      result_mask = '0;
      enq_taken   = '0;
      sel_taken   = '0;
      sel_mask    = vld_q & rdy_q;
      for (int i = 0; i < EnqWidth; i++) begin
         for (int e = 0; e < Depth; e++) begin
            if (!vld_q[e] && !enq_taken[e] && (enq_mask[i] == '0)) begin
               enq_mask[i][e] = 1'b1;
               enq_taken[e]   = 1'b1;
            end
         end
      end
      for (int j = 0; j < SelWidth; j++) begin
         for (int e = 0; e < Depth; e++) begin
            if (sel_mask[e] && !sel_taken[e] && (result_mask[j] == '0)) begin
               result_mask[j][e] = 1'b1;
               sel_taken[e]      = 1'b1;
            end
         end
      end
   end

   // Port-facing handshakes and issue muxes; enq_rdy_o depends only on state, never on enq_vld_i.
   always_comb begin
      deq_data_o = '0;
      deq_idx_o  = '0;
      for (int i = 0; i < EnqWidth; i++) begin
         enq_rdy_o[i] = |enq_mask[i];
         enq_fire[i]  = enq_vld_i[i] & enq_rdy_o[i];
         enq_we[i]    = enq_fire[i] & ~flush_i & ~rst;
      end
      for (int j = 0; j < SelWidth; j++) begin
         deq_vld_o[j] = |result_mask[j];
         deq_fire[j]  = deq_vld_o[j] & deq_rdy_i[j];
         for (int e = 0; e < Depth; e++) begin
            if (result_mask[j][e]) begin
               deq_data_o[j*DataWidth +: DataWidth] = data_q[e];
               deq_idx_o[j*IdxWidth +: IdxWidth]     = IdxWidth'(e);
            end
         end
      end
   end

   // Next valid/ready state: wakeup, then issue frees, then enqueue allocations; flush wipes everything.
   always_comb begin
      vld_nxt = vld_q;
      rdy_nxt = rdy_q;
      deq_clr = '0;
      for (int e = 0; e < Depth; e++) begin
         if (vld_q[e] && !rdy_q[e] && wkup_vld_i && (tag_q[e] == wkup_tag_i))
            rdy_nxt[e] = 1'b1;
      end
      for (int j = 0; j < SelWidth; j++) begin
         if (deq_fire[j])
            deq_clr = deq_clr | result_mask[j];
      end
      for (int e = 0; e < Depth; e++) begin
         if (deq_clr[e]) begin
            vld_nxt[e] = 1'b0;
            rdy_nxt[e] = 1'b0;
         end
      end
      // Allocated slots were free this cycle, so they never collide with the frees above.
      for (int i = 0; i < EnqWidth; i++) begin
         for (int e = 0; e < Depth; e++) begin
            if (enq_fire[i] && enq_mask[i][e]) begin
               vld_nxt[e] = 1'b1;
               rdy_nxt[e] = enq_srdy_i[i] |
                            (wkup_vld_i && (enq_tag_i[i*TagWidth +: TagWidth] == wkup_tag_i));
            end
         end
      end
      if (flush_i) begin
         vld_nxt = '0;
         rdy_nxt = '0;
      end
   end

   // Entry valid/ready registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         rdy_q <= '0;
      end else begin
         vld_q <= vld_nxt;
         rdy_q <= rdy_nxt;
      end
   end

   // Payload and tag storage, written only on a surviving enqueue; not reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < EnqWidth; i++) begin
         for (int e = 0; e < Depth; e++) begin
            if (enq_we[i] && enq_mask[i][e]) begin
               data_q[e] <= enq_data_i[i*DataWidth +: DataWidth];
               tag_q[e]  <= enq_tag_i[i*TagWidth +: TagWidth];
            end
         end
      end
   end

   // Occupancy is a popcount of the registered valid bits.
   always_comb begin
      count_o = '0;
      for (int e = 0; e < Depth; e++)
         count_o = count_o + CntWidth'(vld_q[e]);
   end

   // Consistency flags: issue only from valid entries, no slot shared between ports.
   always_comb begin
      err_deq_invalid = 1'b0;
      err_enq_overlap = 1'b0;
      err_sel_overlap = 1'b0;
      for (int j = 0; j < SelWidth; j++) begin
         if (deq_fire[j] && ((result_mask[j] & vld_q) == '0))
            err_deq_invalid = 1'b1;
         for (int k = j + 1; k < SelWidth; k++)
            if ((result_mask[j] & result_mask[k]) != '0)
               err_sel_overlap = 1'b1;
      end
      for (int i = 0; i < EnqWidth; i++) begin
         if (enq_fire[i] && ((enq_mask[i] & vld_q) != '0))
            err_enq_overlap = 1'b1;
         for (int k = i + 1; k < EnqWidth; k++)
            if ((enq_mask[i] & enq_mask[k]) != '0)
               err_enq_overlap = 1'b1;
      end
   end

   a_deq_on_vld:   assert property (@(posedge clk) disable iff (rst) !err_deq_invalid);
   a_enq_distinct: assert property (@(posedge clk) disable iff (rst) !err_enq_overlap);
   a_sel_distinct: assert property (@(posedge clk) disable iff (rst) !err_sel_overlap);

endmodule

// File: tb/tb_multi_port_wakeup_queue.sv
// Bench for multi_port_wakeup_queue: directed scenarios with literal expectations,
// then randomized traffic, all cross-checked each cycle against an entry-list model.
module tb_multi_port_wakeup_queue;

   logic        clk = 1'b0;
   logic        rst, flush_i;
   logic [1:0]  enq_vld_i, enq_rdy_o, enq_srdy_i;
   logic [15:0] enq_data_i;
   logic [7:0]  enq_tag_i;
   logic        wkup_vld_i;
   logic [3:0]  wkup_tag_i;
   logic [1:0]  deq_vld_o, deq_rdy_i;
   logic [15:0] deq_data_o;
   logic [5:0]  deq_idx_o;
   logic [3:0]  count_o;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   // model state: one record per slot
   bit         m_vld  [8];
   bit         m_rdy  [8];
   logic [3:0] m_tag  [8];
   logic [7:0] m_data [8];

   multi_port_wakeup_queue dut (
      .clk        (clk),
      .rst        (rst),
      .flush_i    (flush_i),
      .enq_vld_i  (enq_vld_i),
      .enq_rdy_o  (enq_rdy_o),
      .enq_data_i (enq_data_i),
      .enq_tag_i  (enq_tag_i),
      .enq_srdy_i (enq_srdy_i),
      .wkup_vld_i (wkup_vld_i),
      .wkup_tag_i (wkup_tag_i),
      .deq_vld_o  (deq_vld_o),
      .deq_rdy_i  (deq_rdy_i),
      .deq_data_o (deq_data_o),
      .deq_idx_o  (deq_idx_o),
      .count_o    (count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model update on each rising edge, from the pre-edge slot lists.
   always @(posedge clk) begin : model
      automatic int nf = 0;
      automatic int nr = 0;
      automatic int fl[8];
      automatic int rl[8];
      automatic bit n_vld[8];
      automatic bit n_rdy[8];
      for (int e = 0; e < 8; e++) begin
         n_vld[e] = m_vld[e];
         n_rdy[e] = m_rdy[e];
         if (!m_vld[e]) begin fl[nf] = e; nf++; end
         if (m_vld[e] && m_rdy[e]) begin rl[nr] = e; nr++; end
      end
      if (rst || flush_i) begin
         for (int e = 0; e < 8; e++) begin n_vld[e] = 0; n_rdy[e] = 0; end
      end else begin
         for (int e = 0; e < 8; e++)
            if (m_vld[e] && !m_rdy[e] && wkup_vld_i && m_tag[e] == wkup_tag_i) n_rdy[e] = 1;
         for (int j = 0; j < 2; j++)
            if (deq_rdy_i[j] && j < nr) begin n_vld[rl[j]] = 0; n_rdy[rl[j]] = 0; end
         for (int i = 0; i < 2; i++)
            if (enq_vld_i[i] && i < nf) begin
               n_vld[fl[i]]  = 1;
               n_rdy[fl[i]]  = enq_srdy_i[i] | (wkup_vld_i && enq_tag_i[i*4 +: 4] == wkup_tag_i);
               m_tag[fl[i]]  = enq_tag_i[i*4 +: 4];
               m_data[fl[i]] = enq_data_i[i*8 +: 8];
            end
      end
      for (int e = 0; e < 8; e++) begin
         m_vld[e] = n_vld[e];
         m_rdy[e] = n_rdy[e];
      end
   end

   // Per-cycle comparison of all outputs against the model, away from the rising edge.
   always @(negedge clk) begin : compare
      automatic int nf = 0;
      automatic int nr = 0;
      automatic int rl[8];
      automatic logic [1:0] exp_rdy;
      automatic logic [1:0] exp_vld;
      if (chk_en) begin
         for (int e = 0; e < 8; e++) begin
            if (!m_vld[e]) nf++;
            if (m_vld[e] && m_rdy[e]) begin rl[nr] = e; nr++; end
         end
         for (int i = 0; i < 2; i++) exp_rdy[i] = (i < nf);
         for (int j = 0; j < 2; j++) exp_vld[j] = (j < nr);
         chk("cmp_enq_rdy", 32'(enq_rdy_o), 32'(exp_rdy));
         chk("cmp_deq_vld", 32'(deq_vld_o), 32'(exp_vld));
         chk("cmp_count",   32'(count_o),   32'(8 - nf));
         for (int j = 0; j < 2; j++)
            if (j < nr) begin
               chk($sformatf("cmp_deq_idx%0d", j),  32'(deq_idx_o[j*3 +: 3]),  32'(rl[j]));
               chk($sformatf("cmp_deq_data%0d", j), 32'(deq_data_o[j*8 +: 8]), 32'(m_data[rl[j]]));
            end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 0; flush_i = 0; enq_vld_i = 0; enq_srdy_i = 0; enq_data_i = 0; enq_tag_i = 0;
      wkup_vld_i = 0; wkup_tag_i = 0; deq_rdy_i = 0;
   endtask

   initial begin
      idle();
      rst = 1;
      step();
      chk_en = 1;
      step();
      idle();
      step();
      chk("rst_enq_rdy", 32'(enq_rdy_o), 32'h3);
      chk("rst_deq_vld", 32'(deq_vld_o), 32'h0);
      chk("rst_count",   32'(count_o),   32'h0);

      // two ready entries enqueued together
      enq_vld_i = 2'b11; enq_srdy_i = 2'b11; enq_data_i = 16'hB2A1;
      step(); idle();
      chk("pair_deq_vld",  32'(deq_vld_o),  32'h3);
      chk("pair_deq_idx",  32'(deq_idx_o),  32'b001_000);
      chk("pair_deq_data", 32'(deq_data_o), 32'hB2A1);
      chk("pair_count",    32'(count_o),    32'd2);
      deq_rdy_i = 2'b11;
      step(); idle();
      chk("pair_drain", 32'(count_o), 32'd0);

      // fill with waiting entries, then one wakeup releases them
      for (int c = 0; c < 4; c++) begin
         enq_vld_i = 2'b11; enq_tag_i = 8'h33; enq_data_i = 16'(c * 16'h0202 + 16'h1110);
         step();
      end
      idle();
      chk("full_enq_rdy", 32'(enq_rdy_o), 32'h0);
      chk("full_deq_vld", 32'(deq_vld_o), 32'h0);
      chk("full_count",   32'(count_o),   32'd8);
      wkup_vld_i = 1; wkup_tag_i = 4'd3;
      step(); idle();
      chk("wake_deq_vld", 32'(deq_vld_o), 32'h3);
      chk("wake_deq_idx", 32'(deq_idx_o), 32'b001_000);
      for (int c = 0; c < 4; c++) begin deq_rdy_i = 2'b11; step(); end
      idle();
      chk("wake_drain", 32'(count_o), 32'd0);

      // seven valid entries leaves exactly one free slot
      for (int c = 0; c < 3; c++) begin enq_vld_i = 2'b11; step(); end
      enq_vld_i = 2'b01; step(); idle();
      chk("seven_enq_rdy", 32'(enq_rdy_o), 32'h1);
      chk("seven_count",   32'(count_o),   32'd7);
      flush_i = 1; step(); idle();

      // port 1 alone takes the second-lowest free slot; slot 0 stays free
      enq_vld_i = 2'b10; enq_srdy_i = 2'b10; enq_data_i = 16'h5C00;
      step(); idle();
      chk("p1_count",   32'(count_o),          32'd1);
      chk("p1_deq_vld", 32'(deq_vld_o),        32'h1);
      chk("p1_idx",     32'(deq_idx_o[2:0]),   32'd1);
      chk("p1_data",    32'(deq_data_o[7:0]),  32'h5C);
      deq_rdy_i = 2'b01; step(); idle();

      // wakeup in the enqueue cycle makes the new entry ready
      enq_vld_i = 2'b01; enq_tag_i = 8'h05; wkup_vld_i = 1; wkup_tag_i = 4'd5;
      step(); idle();
      chk("bypass_deq_vld", 32'(deq_vld_o),      32'h1);
      chk("bypass_idx",     32'(deq_idx_o[2:0]), 32'd0);
      deq_rdy_i = 2'b01; step(); idle();

      // entries 2 and 4 ready; only port 1 accepts
      enq_vld_i = 2'b11; enq_tag_i = 8'h11; step();
      enq_vld_i = 2'b11; enq_tag_i = 8'h10; enq_srdy_i = 2'b01; step();
      enq_vld_i = 2'b01; enq_tag_i = 8'h00; enq_srdy_i = 2'b01; step(); idle();
      chk("two_ready_idx",   32'(deq_idx_o), 32'b100_010);
      chk("two_ready_count", 32'(count_o),   32'd5);
      deq_rdy_i = 2'b10; step(); idle();
      chk("partial_count",   32'(count_o),        32'd4);
      chk("partial_deq_vld", 32'(deq_vld_o),      32'h1);
      chk("partial_idx",     32'(deq_idx_o[2:0]), 32'd2);

      // flush beats simultaneous enqueue and issue
      flush_i = 1; enq_vld_i = 2'b11; enq_srdy_i = 2'b11; deq_rdy_i = 2'b11;
      step(); idle();
      chk("flush_count",   32'(count_o),   32'd0);
      chk("flush_deq_vld", 32'(deq_vld_o), 32'h0);
      chk("flush_enq_rdy", 32'(enq_rdy_o), 32'h3);

      // randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rst        = ($urandom_range(0, 149) == 0);
         flush_i    = ($urandom_range(0, 59) == 0);
         enq_vld_i  = 2'($urandom_range(0, 3));
         enq_srdy_i = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
         enq_data_i = 16'($urandom);
         enq_tag_i  = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
         wkup_vld_i = ($urandom_range(0, 2) == 0);
         wkup_tag_i = 4'($urandom_range(0, 3));
         deq_rdy_i  = 2'($urandom_range(0, 3));
         step();
      end
      idle();
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
